// File: rtl/sprite_position_latch.sv
// sprite_position_latch
// Decodes packed sprite-position words from the Nios position-table PIO into
// a shadow bank. The shadow bank is copied to the active bank only on a
// frame_start pulse, so the HDMI sprite renderer always reads a consistent
// frame through the registered random-read port.
// Optional build macro: SPRITE_POSITION_CLAMP_EN. When it is defined,
// out-of-range coordinates are clamped to X_MAX/Y_MAX and the word is
// accepted. When it is undefined, such words are rejected and counted.
module sprite_position_latch #(
  parameter int N_SPRITES = 5,
  parameter int COORD_W   = 12,
  parameter int X_MAX     = 1279,
  parameter int Y_MAX     = 719
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  input  logic [31:0]          position_table_export,
  input  logic                 frame_start,
  input  logic [2:0]           rd_idx,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic [1:0]           rd_dir,
  output logic                 rd_valid,
  output logic [N_SPRITES-1:0] valid_mask,
  output logic                 update_pending,
  output logic                 commit_pulse,
  output logic [7:0]           err_cnt
);

  localparam logic [3:0]  N_LIM = 4'(N_SPRITES);
  localparam logic [11:0] X_LIM = 12'(X_MAX);
  localparam logic [11:0] Y_LIM = 12'(Y_MAX);

  // Word fields; bits [25:24] are reserved and deliberately ignored
  logic        w_toggle;
  logic [2:0]  w_id;
  logic [1:0]  w_dir;
  logic [11:0] w_x_raw;
  logic [11:0] w_y_raw;
  logic [1:0]  w_unused_rsvd;

  assign w_toggle      = position_table_export[31];
  assign w_id          = position_table_export[30:28];
  assign w_dir         = position_table_export[27:26];
  assign w_unused_rsvd = position_table_export[25:24];
  assign w_x_raw       = position_table_export[23:12];
  assign w_y_raw       = position_table_export[11:0];

  // Control state
  logic                 r_armed;
  logic                 r_prev_toggle;
  logic                 r_update_pending;
  logic                 r_commit_pulse;
  logic [7:0]           r_err_cnt;

  // Shadow and active banks
  logic [COORD_W-1:0]   r_sh_x   [N_SPRITES];
  logic [COORD_W-1:0]   r_sh_y   [N_SPRITES];
  logic [1:0]           r_sh_dir [N_SPRITES];
  logic [N_SPRITES-1:0] r_sh_valid;
  logic [COORD_W-1:0]   r_act_x  [N_SPRITES];
  logic [COORD_W-1:0]   r_act_y  [N_SPRITES];
  logic [1:0]           r_act_dir[N_SPRITES];
  logic [N_SPRITES-1:0] r_valid_mask;

  // Read port registers
  logic [COORD_W-1:0]   r_rd_x;
  logic [COORD_W-1:0]   r_rd_y;
  logic [1:0]           r_rd_dir;
  logic                 r_rd_valid;

  // Decode results
  logic                 w_write;
  logic                 w_id_ok;
  logic                 w_x_over;
  logic                 w_y_over;
  logic                 w_range_ok;
  logic [11:0]          w_x_st;
  logic [11:0]          w_y_st;
  logic                 w_accept;
  logic                 w_reject;
  logic                 w_commit;

  // Classify the incoming word: write detect, id check and range rule
  always_comb begin
    w_write  = r_armed & (w_toggle ^ r_prev_toggle);
    w_id_ok  = ({1'b0, w_id} < N_LIM);
    w_x_over = (w_x_raw > X_LIM);
    w_y_over = (w_y_raw > Y_LIM);
`ifdef SPRITE_POSITION_CLAMP_EN
    w_x_st     = w_x_over ? X_LIM : w_x_raw;
    w_y_st     = w_y_over ? Y_LIM : w_y_raw;
    w_range_ok = 1'b1;
`else
    w_x_st     = w_x_raw;
    w_y_st     = w_y_raw;
    w_range_ok = ~(w_x_over | w_y_over);
`endif
    w_accept = w_write & w_id_ok & w_range_ok;
    w_reject = w_write & ~w_accept;
    w_commit = frame_start & r_update_pending;
  end

  // Arming, toggle tracking, pending flag, commit pulse and error counter
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_armed          <= 1'b0;
      r_prev_toggle    <= 1'b0;
      r_update_pending <= 1'b0;
      r_commit_pulse   <= 1'b0;
      r_err_cnt        <= 8'd0;
    end else begin
      r_armed        <= 1'b1;
      r_prev_toggle  <= w_toggle;
      r_commit_pulse <= w_commit;
      // A write landing together with a commit keeps the flag set so that
      // the new entry goes out on the following frame.
      if (w_accept) begin
        r_update_pending <= 1'b1;
      end else if (w_commit) begin
        r_update_pending <= 1'b0;
      end else begin
        r_update_pending <= r_update_pending;
      end
      if (w_reject && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_err_cnt <= r_err_cnt;
      end
    end
  end

  // Shadow bank: accepted words update the addressed slot
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        r_sh_x[i]   <= '0;
        r_sh_y[i]   <= '0;
        r_sh_dir[i] <= 2'd0;
      end
      r_sh_valid <= '0;
    end else begin
      for (int i = 0; i < N_SPRITES; i++) begin
        if (w_accept && (w_id == 3'(i))) begin
          r_sh_x[i]     <= COORD_W'(w_x_st);
          r_sh_y[i]     <= COORD_W'(w_y_st);
          r_sh_dir[i]   <= w_dir;
          r_sh_valid[i] <= 1'b1;
        end
      end
    end
  end

  // Active bank: copy of the pre-edge shadow contents on commit
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        r_act_x[i]   <= '0;
        r_act_y[i]   <= '0;
        r_act_dir[i] <= 2'd0;
      end
      r_valid_mask <= '0;
    end else if (w_commit) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        r_act_x[i]   <= r_sh_x[i];
        r_act_y[i]   <= r_sh_y[i];
        r_act_dir[i] <= r_sh_dir[i];
      end
      r_valid_mask <= r_sh_valid;
    end else begin
      r_valid_mask <= r_valid_mask;
    end
  end

  // Registered read port; indices outside the sprite range read as zero
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_rd_dir   <= 2'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_x     <= '0;
      r_rd_y     <= '0;
      r_rd_dir   <= 2'd0;
      r_rd_valid <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        if (rd_idx == 3'(i)) begin
          r_rd_x     <= r_act_x[i];
          r_rd_y     <= r_act_y[i];
          r_rd_dir   <= r_act_dir[i];
          r_rd_valid <= r_valid_mask[i];
        end
      end
    end
  end

  assign rd_x           = r_rd_x;
  assign rd_y           = r_rd_y;
  assign rd_dir         = r_rd_dir;
  assign rd_valid       = r_rd_valid;
  assign valid_mask     = r_valid_mask;
  assign update_pending = r_update_pending;
  assign commit_pulse   = r_commit_pulse;
  assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_sprite_position_latch.sv
// Scoreboard bench for sprite_position_latch. Stimulus pushes expected
// values tagged with the cycle they are due in; a negedge monitor pops and
// compares them. Honours SPRITE_POSITION_CLAMP_EN for the range case.
module tb_sprite_position_latch;

  localparam int F_RD_X   = 0;
  localparam int F_RD_Y   = 1;
  localparam int F_RD_DIR = 2;
  localparam int F_RD_VAL = 3;
  localparam int F_VMASK  = 4;
  localparam int F_PEND   = 5;
  localparam int F_COMMIT = 6;
  localparam int F_ERR    = 7;

  typedef struct {
    string       name;
    int          field;
    logic [31:0] exp;
    int          due;
  } chk_t;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [31:0] position_table_export = 32'd0;
  logic        frame_start = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic [11:0] rd_x;
  logic [11:0] rd_y;
  logic [1:0]  rd_dir;
  logic        rd_valid;
  logic [4:0]  valid_mask;
  logic        update_pending;
  logic        commit_pulse;
  logic [7:0]  err_cnt;

  chk_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  logic tog = 1'b0;

  sprite_position_latch dut (
    .clk_clk               (clk_clk),
    .reset_reset           (reset_reset),
    .position_table_export (position_table_export),
    .frame_start           (frame_start),
    .rd_idx                (rd_idx),
    .rd_x                  (rd_x),
    .rd_y                  (rd_y),
    .rd_dir                (rd_dir),
    .rd_valid              (rd_valid),
    .valid_mask            (valid_mask),
    .update_pending        (update_pending),
    .commit_pulse          (commit_pulse),
    .err_cnt               (err_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  always @(posedge clk_clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has come due
  always @(negedge clk_clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      chk_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.field)
        F_RD_X:   act = 32'(rd_x);
        F_RD_Y:   act = 32'(rd_y);
        F_RD_DIR: act = 32'(rd_dir);
        F_RD_VAL: act = 32'(rd_valid);
        F_VMASK:  act = 32'(valid_mask);
        F_PEND:   act = 32'(update_pending);
        F_COMMIT: act = 32'(commit_pulse);
        F_ERR:    act = 32'(err_cnt);
        default:  act = 32'hDEAD_BEEF;
      endcase
      n_vec = n_vec + 1;
      if (act !== e.exp) begin
        n_miss = n_miss + 1;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.name, cyc, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic exp_push(input string name, input int field, input logic [31:0] val,
                          input int delay);
    chk_t e;
    e.name  = name;
    e.field = field;
    e.exp   = val;
    e.due   = cyc + delay;
    q.push_back(e);
  endtask

  task automatic wr(input logic [2:0] id, input logic [1:0] d, input logic [11:0] x,
                    input logic [11:0] y);
    tog = ~tog;
    position_table_export = {tog, id, d, 2'b00, x, y};
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    exp_push("rst_pending", F_PEND, 32'd0, 0);
    exp_push("rst_vmask", F_VMASK, 32'd0, 0);
    exp_push("rst_err", F_ERR, 32'd0, 0);
    exp_push("rst_commit", F_COMMIT, 32'd0, 0);
    exp_push("rst_rd_x", F_RD_X, 32'd0, 0);
    exp_push("rst_rd_valid", F_RD_VAL, 32'd0, 0);

    // Arming cycle: toggle=1 word held, nothing may be written
    tick();
    reset_reset = 1'b0;
    tog = 1'b1;
    position_table_export = 32'h8010_0200;
    tick();
    tick();
    exp_push("arm_pending", F_PEND, 32'd0, 0);
    exp_push("arm_vmask", F_VMASK, 32'd0, 0);

    // First write, commit, read back
    tick(); wr(3'd0, 2'd0, 12'd256, 12'd512);
    tick(); frame_start = 1'b1;
    exp_push("w0_pending", F_PEND, 32'd1, 0);
    tick(); frame_start = 1'b0; rd_idx = 3'd0;
    exp_push("w0_commit", F_COMMIT, 32'd1, 0);
    exp_push("w0_vmask", F_VMASK, 32'd1, 0);
    exp_push("w0_pending_clr", F_PEND, 32'd0, 0);
    tick();
    exp_push("w0_commit_one", F_COMMIT, 32'd0, 0);
    exp_push("w0_rd_x", F_RD_X, 32'd256, 0);
    exp_push("w0_rd_y", F_RD_Y, 32'd512, 0);
    exp_push("w0_rd_valid", F_RD_VAL, 32'd1, 0);

    // Write coinciding with frame_start lands in shadow only
    tick(); wr(3'd1, 2'd1, 12'd100, 12'd200);
    tick(); wr(3'd2, 2'd2, 12'd10, 12'd20); frame_start = 1'b1;
    exp_push("w1_pending", F_PEND, 32'd1, 0);
    tick(); frame_start = 1'b0; rd_idx = 3'd1;
    exp_push("sim_commit", F_COMMIT, 32'd1, 0);
    exp_push("sim_pending", F_PEND, 32'd1, 0);
    exp_push("sim_vmask", F_VMASK, 32'h03, 0);
    tick(); rd_idx = 3'd2;
    exp_push("w1_rd_x", F_RD_X, 32'd100, 0);
    exp_push("w1_rd_y", F_RD_Y, 32'd200, 0);
    exp_push("w1_rd_dir", F_RD_DIR, 32'd1, 0);
    tick(); frame_start = 1'b1;
    exp_push("w2_not_committed", F_RD_VAL, 32'd0, 0);
    exp_push("w2_rd_x_zero", F_RD_X, 32'd0, 0);
    tick(); frame_start = 1'b0;
    exp_push("w2_commit", F_COMMIT, 32'd1, 0);
    exp_push("w2_vmask", F_VMASK, 32'h07, 0);
    exp_push("w2_pending_clr", F_PEND, 32'd0, 0);
    tick();
    exp_push("w2_rd_x", F_RD_X, 32'd10, 0);
    exp_push("w2_rd_y", F_RD_Y, 32'd20, 0);
    exp_push("w2_rd_dir", F_RD_DIR, 32'd2, 0);
    exp_push("w2_rd_valid", F_RD_VAL, 32'd1, 0);

    // Bad id: counted, shadow untouched; 300 of them saturate at 255
    tick(); wr(3'd6, 2'd0, 12'd5, 12'd5);
    tick(); wr(3'd6, 2'd0, 12'd5, 12'd5);
    exp_push("bad_id_err1", F_ERR, 32'd1, 0);
    exp_push("bad_id_pending", F_PEND, 32'd0, 0);
    for (int i = 0; i < 298; i++) begin
      tick(); wr(3'd6, 2'd0, 12'd5, 12'd5);
    end
    tick();
    exp_push("err_saturate", F_ERR, 32'd255, 0);

    // Reset mid-frame discards pending data, no commit afterwards
    tick(); wr(3'd3, 2'd0, 12'd7, 12'd7);
    tick(); reset_reset = 1'b1;
    exp_push("pre_rst_pending", F_PEND, 32'd1, 0);
    tick(); reset_reset = 1'b0;
    exp_push("mid_rst_pending", F_PEND, 32'd0, 0);
    exp_push("mid_rst_err", F_ERR, 32'd0, 0);
    exp_push("mid_rst_vmask", F_VMASK, 32'd0, 0);
    exp_push("mid_rst_rd_x", F_RD_X, 32'd0, 0);
    tick(); frame_start = 1'b1;
    tick(); frame_start = 1'b0;
    exp_push("idle_fs_commit", F_COMMIT, 32'd0, 0);

    // Out-of-range x
    tick(); wr(3'd3, 2'd1, 12'd2000, 12'd100);
    tick(); frame_start = 1'b1;
`ifdef SPRITE_POSITION_CLAMP_EN
    exp_push("clamp_pending", F_PEND, 32'd1, 0);
    exp_push("clamp_err", F_ERR, 32'd0, 0);
`else
    exp_push("range_err", F_ERR, 32'd1, 0);
    exp_push("range_pending", F_PEND, 32'd0, 0);
`endif
    tick(); frame_start = 1'b0; rd_idx = 3'd3;
`ifdef SPRITE_POSITION_CLAMP_EN
    exp_push("clamp_commit", F_COMMIT, 32'd1, 0);
    exp_push("clamp_vmask", F_VMASK, 32'h08, 0);
`else
    exp_push("range_commit", F_COMMIT, 32'd0, 0);
    exp_push("range_vmask", F_VMASK, 32'd0, 0);
`endif
    tick();
`ifdef SPRITE_POSITION_CLAMP_EN
    exp_push("clamp_rd_x", F_RD_X, 32'd1279, 0);
    exp_push("clamp_rd_y", F_RD_Y, 32'd100, 0);
    exp_push("clamp_rd_valid", F_RD_VAL, 32'd1, 0);
`else
    exp_push("range_rd_valid", F_RD_VAL, 32'd0, 0);
    exp_push("range_rd_x", F_RD_X, 32'd0, 0);
`endif

    // Back-to-back writes to the same slot: last one wins
    tick(); wr(3'd4, 2'd0, 12'd1, 12'd1);
    tick(); wr(3'd4, 2'd3, 12'd2, 12'd3);
    tick(); frame_start = 1'b1;
    tick(); frame_start = 1'b0; rd_idx = 3'd4;
    exp_push("b2b_commit", F_COMMIT, 32'd1, 0);
`ifdef SPRITE_POSITION_CLAMP_EN
    exp_push("b2b_vmask", F_VMASK, 32'h18, 0);
`else
    exp_push("b2b_vmask", F_VMASK, 32'h10, 0);
`endif
    tick(); frame_start = 1'b1;
    exp_push("b2b_rd_x", F_RD_X, 32'd2, 0);
    exp_push("b2b_rd_y", F_RD_Y, 32'd3, 0);
    exp_push("b2b_rd_dir", F_RD_DIR, 32'd3, 0);
    exp_push("b2b_rd_valid", F_RD_VAL, 32'd1, 0);
    tick(); frame_start = 1'b0; rd_idx = 3'd7;
    exp_push("no_write_commit", F_COMMIT, 32'd0, 0);
    tick();
    exp_push("oob_rd_x", F_RD_X, 32'd0, 0);
    exp_push("oob_rd_dir", F_RD_DIR, 32'd0, 0);
    exp_push("oob_rd_valid", F_RD_VAL, 32'd0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_vec = n_vec + 1;
      n_miss = n_miss + 1;
      $display("FAIL drain: got %0d pending checks, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
